// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC, ROM word capture FIFO and valid/ready hand-off to decode.
// Optional IFETCH_BYPASS_EN macro adds a 0-cycle imem_rd -> out_* path when the queue is empty.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_a,
    input  logic [31:0]        imem_rd,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc4
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    logic [31:0]   fetch_pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          empty, pop, qpop, push, take;
    logic [31:0]   head_instr, head_pc;
    assign empty      = count == '0;
    assign imem_a     = fetch_pc[IMEM_AW+1:2];
    // empty head reads as zero so flushed entries never leak onto out_*
    assign head_instr = empty ? '0 : q_instr[rd_ptr];
    assign head_pc    = empty ? '0 : q_pc[rd_ptr];
`ifdef IFETCH_BYPASS_EN
    logic byp;
    assign byp       = empty & !redirect_valid & rst_n;
    assign take      = byp & out_ready;
    assign out_valid = !empty | byp;
    assign out_instr = byp ? imem_rd : head_instr;
    assign out_pc    = byp ? fetch_pc : head_pc;
`else
    assign take      = 1'b0;
    assign out_valid = !empty;
    assign out_instr = head_instr;
    assign out_pc    = head_pc;
`endif
    assign out_pc4 = out_pc + 32'd4;
    assign pop     = out_valid & out_ready;
    assign qpop    = pop & !empty;
    assign push    = !redirect_valid & (count != FULL | qpop) & !take;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= imem_rd;
                q_pc[wr_ptr]    <= fetch_pc;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (qpop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push | take)
                fetch_pc <= fetch_pc + 32'd4;
            count <= count + (PW+1)'(push) - (PW+1)'(qpop);
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed stimulus with a PC scoreboard checked at every decode handshake.
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr, out_pc, out_pc4;
    logic [31:0] rom [64];
    logic [31:0] exp_q [$];
    logic [31:0] nxt;
    int          n_chk = 0;
    int          n_fail = 0;

    ifetch_queue dut (
        .clk(clk), .rst_n(rst_n), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4)
    );

    always #5 clk = ~clk;
    assign imem_rd = rom[imem_a];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic expect_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
        nxt = start + 32'(4 * n);
    endtask

    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_chk++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_extra: observed pop of pc %h expected none", out_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e);
                chk("sb_instr", out_instr, rom[e[7:2]]);
                chk("sb_pc4", out_pc4, e + 32'd4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
        out_ready = 1'b0;
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic redirect(input logic [31:0] pc, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        out_ready = rdy;
        cyc();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | 32'(i);
        rom[0]  = 32'h2001_0007;
        rom[1]  = 32'h2002_0008;
        rom[18] = 32'h0064_2020;
        // reset state, decode ready from the start
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_imem_a", 32'(imem_a), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_run(0, 2);
        cyc();
`ifndef IFETCH_BYPASS_EN
        chk("t1_c1_pc", out_pc, 0);
        chk("t1_c1_instr", out_instr, 32'h2001_0007);
`endif
        cyc();
`ifndef IFETCH_BYPASS_EN
        chk("t1_c2_pc", out_pc, 4);
        chk("t1_c2_instr", out_instr, 32'h2002_0008);
`endif
        drain(4);
        // saturate with decode stalled from reset
        rst_n = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        #1;
        chk("t2_rst_valid", 32'(out_valid), 0);
        cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        chk("t2_imem_a", 32'(imem_a), 4);
        chk("t2_out_pc", out_pc, 0);
        chk("t2_valid", 32'(out_valid), 1);
        expect_run(0, 5);
        drain(20);
        // redirect with simultaneous pop of the head
        expect_run(nxt, 1);
        redirect(32'h48, 1'b1);
        chk("t3_head_once", exp_q.size(), 0);
`ifndef IFETCH_BYPASS_EN
        chk("t3_bubble", 32'(out_valid), 0);
        cyc();
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_pc", out_pc, 32'h48);
        chk("t3_instr", out_instr, 32'h0064_2020);
`endif
        expect_run(32'h48, 3);
        drain(10);
        // unaligned target and ROM index wrap
        redirect(32'h4B, 1'b0);
        chk("t4_align", 32'(imem_a), 18);
        expect_run(32'h48, 2);
        drain(10);
        redirect(32'hF8, 1'b0);
        chk("t4_imem62", 32'(imem_a), 62);
        expect_run(32'hF8, 3);
        drain(10);
        redirect(32'hFFFF_FFF8, 1'b0);
        expect_run(32'hFFFF_FFF8, 3);
        drain(10);
        // full queue, pop and redirect together
        repeat (6) cyc();
        chk("t5_full_valid", 32'(out_valid), 1);
        expect_run(nxt, 1);
        redirect(32'h10, 1'b1);
        chk("t5_head_once", exp_q.size(), 0);
        expect_run(32'h10, 2);
        drain(10);
        // back-to-back redirects, last wins
        redirect(32'h80, 1'b0);
        redirect(32'h20, 1'b1);
        chk("t5_b2b_none", exp_q.size(), 0);
        expect_run(32'h20, 2);
        drain(10);
        // asynchronous reset between edges while full
        repeat (6) cyc();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_pc", out_pc, 0);
        chk("t6_async_imem_a", 32'(imem_a), 0);
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
`ifdef IFETCH_BYPASS_EN
        chk("t6_byp_valid", 32'(out_valid), 1);
        chk("t6_byp_pc", out_pc, 0);
`endif
        expect_run(0, 3);
        drain(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
